// File: rtl/jam_cost_server.sv
// jam_cost_server: holds the N x N JAM cost table and answers (W,J) lookups.
// Optional build macro LOOKUP_CNT_EN adds the lookup_cnt output port.
module jam_cost_server #(
    parameter int N      = 8,
    parameter int IDX_W  = 3,
    parameter int COST_W = 7
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [COST_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              ld_err,
    output logic              table_ready,
    input  logic [IDX_W-1:0]  W,
    input  logic [IDX_W-1:0]  J,
    output logic [COST_W-1:0] Cost,
    input  logic              jam_valid,
    output logic              done
`ifdef LOOKUP_CNT_EN
    ,
    output logic [15:0]       lookup_cnt
`endif
);

    localparam int AW = (N * N > 1) ? $clog2(N * N) : 1;
    localparam logic [AW-1:0] LAST = AW'(N * N - 1);
    localparam logic [IDX_W:0] NLIM = (IDX_W + 1)'(N);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SERVE,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [AW-1:0]     ptr;
    logic [AW-1:0]     idx;
    logic              accept;
    logic              last_beat;
    logic              in_range;
    logic              serving;
    logic [COST_W-1:0] mem [N*N];

    assign ld_ready    = (state == LOAD);
    assign serving     = (state == SERVE) || (state == DONE);
    assign table_ready = serving;
    assign done        = (state == DONE);

    // A restart pulse takes priority over a beat presented in the same cycle.
    assign accept    = ld_ready && ld_valid && !ld_start;
    assign last_beat = accept && (ptr == LAST);

    assign idx      = AW'(W) * AW'(N) + AW'(J);
    assign in_range = ({1'b0, W} < NLIM) && ({1'b0, J} < NLIM);

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; ld_start re-enters LOAD from any state.
    always_comb begin
        state_nxt = state;
        if (ld_start) begin
            state_nxt = LOAD;
        end else begin
            unique case (state)
                IDLE:  state_nxt = IDLE;
                LOAD:  if (last_beat) state_nxt = SERVE;
                SERVE: if (jam_valid) state_nxt = DONE;
                DONE:  state_nxt = DONE;
            endcase
        end
    end

    // Load pointer: cleared on restart, advances per accepted beat.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ptr <= '0;
        end else if (ld_start) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= last_beat ? '0 : ptr + 1'b1;
        end
    end

    // Table storage, intentionally without reset.
    always_ff @(posedge CLK) begin
        if (accept) begin
            mem[ptr] <= ld_data;
        end
    end

    // Registered lookup; zero outside SERVE/DONE or for out-of-range indices.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Cost <= '0;
        end else if (serving && in_range) begin
            Cost <= mem[idx];
        end else begin
            Cost <= '0;
        end
    end

    // Sticky flag for beats offered while not loading.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ld_err <= 1'b0;
        end else if (ld_valid && (state != LOAD)) begin
            ld_err <= 1'b1;
        end
    end

`ifdef LOOKUP_CNT_EN
    // Saturating count of edges spent in SERVE; frozen in DONE.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lookup_cnt <= '0;
        end else if (ld_start) begin
            lookup_cnt <= '0;
        end else if ((state == SERVE) && (lookup_cnt != 16'hFFFF)) begin
            lookup_cnt <= lookup_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_jam_cost_server.sv
// tb_jam_cost_server: random/directed stimulus with an expectation scoreboard.
// A negedge monitor compares each queued expectation in its due cycle.
module tb_jam_cost_server;

    localparam int SEL_COST = 0;
    localparam int SEL_TRDY = 1;
    localparam int SEL_LRDY = 2;
    localparam int SEL_DONE = 3;
    localparam int SEL_LERR = 4;

    logic       CLK = 1'b0;
    logic       RST;
    logic       ld_start;
    logic       ld_valid;
    logic [6:0] ld_data;
    logic       ld_ready;
    logic       ld_err;
    logic       table_ready;
    logic [2:0] W;
    logic [2:0] J;
    logic [6:0] Cost;
    logic       jam_valid;
    logic       done;

    jam_cost_server dut (
        .CLK(CLK),
        .RST(RST),
        .ld_start(ld_start),
        .ld_valid(ld_valid),
        .ld_data(ld_data),
        .ld_ready(ld_ready),
        .ld_err(ld_err),
        .table_ready(table_ready),
        .W(W),
        .J(J),
        .Cost(Cost),
        .jam_valid(jam_valid),
        .done(done)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int    due;
        int    sel;
        int    val;
        string name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   got;
    int   ref_tbl [64];
    bit   serving = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic void want(int due, int sel, int val, string name);
        exp_t e;
        e.due = due;
        e.sel = sel;
        e.val = val;
        e.name = name;
        sb.push_back(e);
    endfunction

    function automatic int sig(int sel);
        case (sel)
            SEL_COST: return int'(Cost);
            SEL_TRDY: return int'(table_ready);
            SEL_LRDY: return int'(ld_ready);
            SEL_DONE: return int'(done);
            default:  return int'(ld_err);
        endcase
    endfunction

    // Monitor: compare every expectation that falls due this cycle.
    always @(negedge CLK) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                checks++;
                got = sig(sb[i].sel);
                if (got != sb[i].val) begin
                    failures++;
                    $display("FAIL %s cyc=%0d got=%0d want=%0d",
                             sb[i].name, cyc, got, sb[i].val);
                end
                sb.delete(i);
            end else if (sb[i].due < cyc) begin
                checks++;
                failures++;
                $display("FAIL %s cyc=%0d stale expectation due=%0d",
                         sb[i].name, cyc, sb[i].due);
                sb.delete(i);
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Reference: Cost(w,j) is entry w*8+j once the table is being served, else 0.
    task automatic lookup(input int w, input int j);
        W = 3'(w);
        J = 3'(j);
        want(cyc + 1, SEL_COST, serving ? ref_tbl[w*8+j] : 0, "cost");
        step();
    endtask

    task automatic rand_lookups(input int n);
        for (int i = 0; i < n; i++) begin
            lookup($urandom_range(0, 7), $urandom_range(0, 7));
        end
    endtask

    // pat: 0 value=index, 1 value=63-index, 2 random.
    task automatic do_load(input int pat, input int beats,
                           input bit toggle, input bit junk);
        int n;
        bit ph;
        int v;
        serving = 0;
        ld_start = 1'b1;
        ld_valid = junk;
        ld_data = 7'($urandom);
        want(cyc + 1, SEL_LRDY, 1, "ld_ready_after_start");
        want(cyc + 1, SEL_TRDY, 0, "table_ready_after_start");
        want(cyc + 1, SEL_DONE, 0, "done_after_start");
        step();
        ld_start = 1'b0;
        want(cyc + 1, SEL_COST, 0, "cost_in_load");
        n = 0;
        ph = 1'b0;
        while (n < beats) begin
            want(cyc, SEL_LRDY, 1, "ld_ready_in_load");
            if (toggle && ph) begin
                ld_valid = 1'b0;
            end else begin
                case (pat)
                    0:       v = n;
                    1:       v = 63 - n;
                    default: v = int'($urandom_range(0, 127));
                endcase
                ld_valid = 1'b1;
                ld_data = 7'(v);
                ref_tbl[n] = v;
                if (n == 63) begin
                    want(cyc, SEL_TRDY, 0, "table_ready_before_last");
                    want(cyc + 1, SEL_TRDY, 1, "table_ready_after_last");
                    want(cyc + 1, SEL_LRDY, 0, "ld_ready_after_last");
                end
                n++;
            end
            ph = ~ph;
            step();
        end
        ld_valid = 1'b0;
        if (beats == 64) serving = 1;
    endtask

    initial begin
        RST = 1'b1;
        ld_start = 1'b0;
        ld_valid = 1'b0;
        ld_data = '0;
        W = '0;
        J = '0;
        jam_valid = 1'b0;
        step();
        want(cyc, SEL_LRDY, 0, "rst_ld_ready");
        want(cyc, SEL_COST, 0, "rst_cost");
        step();
        RST = 1'b0;
        want(cyc, SEL_LRDY, 0, "rst_ld_ready");
        want(cyc, SEL_LERR, 0, "rst_ld_err");
        want(cyc, SEL_TRDY, 0, "rst_table_ready");
        want(cyc, SEL_COST, 0, "rst_cost");
        want(cyc, SEL_DONE, 0, "rst_done");
        step();

        ld_valid = 1'b1;
        jam_valid = 1'b1;
        want(cyc + 1, SEL_LERR, 1, "ld_err_idle");
        want(cyc + 1, SEL_DONE, 0, "jam_valid_idle_ignored");
        step();
        ld_valid = 1'b0;
        jam_valid = 1'b0;
        lookup(3, 3);

        do_load(0, 64, 0, 0);
        lookup(3, 5);
        lookup(7, 7);
        lookup(0, 0);
        lookup(7, 0);
        rand_lookups(30);

        jam_valid = 1'b1;
        want(cyc, SEL_DONE, 0, "done_before_jam");
        want(cyc + 1, SEL_DONE, 1, "done_after_jam");
        lookup($urandom_range(0, 7), $urandom_range(0, 7));
        jam_valid = 1'b0;
        want(cyc + 1, SEL_DONE, 1, "done_held");
        want(cyc, SEL_LERR, 1, "ld_err_sticky");
        rand_lookups(5);

        do_load(2, 64, 1, 0);
        lookup(0, 0);
        lookup(7, 0);
        rand_lookups(30);
        want(cyc, SEL_LERR, 1, "ld_err_sticky2");

        do_load(2, 10, 0, 0);
        do_load(0, 64, 0, 1);
        lookup(3, 5);
        rand_lookups(20);

        do_load(2, 20, 0, 0);
        RST = 1'b1;
        #1;
        want(cyc, SEL_LRDY, 0, "midload_rst_ld_ready");
        want(cyc, SEL_TRDY, 0, "midload_rst_table_ready");
        want(cyc, SEL_COST, 0, "midload_rst_cost");
        want(cyc, SEL_LERR, 0, "midload_rst_ld_err");
        step();
        RST = 1'b0;
        serving = 0;
        lookup(2, 6);

        do_load(1, 64, 0, 0);
        lookup(0, 0);
        lookup(7, 7);
        rand_lookups(20);
        ld_valid = 1'b1;
        want(cyc + 1, SEL_LERR, 1, "ld_err_serve");
        step();
        ld_valid = 1'b0;
        rand_lookups(5);

        repeat (3) step();
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
